// File: rtl/dcache_nway_if.sv
// Request/response bundle between the cache controller and dcache_nway.
// master: cc_* request side; slave: cache_* result side. DCACHE_STATS_EN adds counters.
interface dcache_nway_if #(
    parameter int ADR_LENGTH  = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   cc_req_i;
    logic                   cc_we_i;
    logic                   cc_deload_i;
    logic [ADR_LENGTH-1:0]  cc_adr_i;
    logic [DATA_LENGTH-1:0] cc_dat_i;
    logic                   cache_ack_o;
    logic [DATA_LENGTH-1:0] cache_dat_o;
    logic                   cache_hit_o;
    logic                   cache_free_o;
    logic                   cache_evict_o;
    logic [ADR_LENGTH-1:0]  cache_evict_adr_o;
    logic [DATA_LENGTH-1:0] cache_evict_dat_o;
`ifdef DCACHE_STATS_EN
    logic [15:0]            cache_hit_cnt_o;
    logic [15:0]            cache_miss_cnt_o;

    modport master (
        output cc_req_i, cc_we_i, cc_deload_i, cc_adr_i, cc_dat_i,
        input  cache_ack_o, cache_dat_o, cache_hit_o, cache_free_o,
        input  cache_evict_o, cache_evict_adr_o, cache_evict_dat_o,
        input  cache_hit_cnt_o, cache_miss_cnt_o
    );
    modport slave (
        input  cc_req_i, cc_we_i, cc_deload_i, cc_adr_i, cc_dat_i,
        output cache_ack_o, cache_dat_o, cache_hit_o, cache_free_o,
        output cache_evict_o, cache_evict_adr_o, cache_evict_dat_o,
        output cache_hit_cnt_o, cache_miss_cnt_o
    );
`else
    modport master (
        output cc_req_i, cc_we_i, cc_deload_i, cc_adr_i, cc_dat_i,
        input  cache_ack_o, cache_dat_o, cache_hit_o, cache_free_o,
        input  cache_evict_o, cache_evict_adr_o, cache_evict_dat_o
    );
    modport slave (
        input  cc_req_i, cc_we_i, cc_deload_i, cc_adr_i, cc_dat_i,
        output cache_ack_o, cache_dat_o, cache_hit_o, cache_free_o,
        output cache_evict_o, cache_evict_adr_o, cache_evict_dat_o
    );
`endif
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative data cache, one word per line, true-LRU, req/ack.
// Ports: clk, rst (async active-high), bus (dcache_nway_if.slave: cc_* in, cache_* out).
// Optional: define DCACHE_STATS_EN for saturating hit/miss counters on bus.
module dcache_nway #(
    parameter int WAY_NUMBER   = 2,
    parameter int ADR_LENGTH   = 32,
    parameter int INDEX_LENGTH = 5,
    parameter int TAG_LENGTH   = 22,
    parameter int DATA_LENGTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    dcache_nway_if.slave  bus
);
    localparam int SETS = 1 << INDEX_LENGTH;
    localparam int AW   = (WAY_NUMBER > 1) ? $clog2(WAY_NUMBER) : 1;
    localparam int KL   = INDEX_LENGTH + TAG_LENGTH;

    typedef logic [AW-1:0] age_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t                 state;
    logic                   we_q;
    logic                   deload_q;
    logic [KL-1:0]          key_q;
    logic [DATA_LENGTH-1:0] dat_q;
    logic                   hit_q;
    age_t                   way_q;

    logic [WAY_NUMBER-1:0]  valid_q [SETS];
    age_t                   age_q   [SETS][WAY_NUMBER];
    logic [TAG_LENGTH-1:0]  tag_mem [SETS][WAY_NUMBER];
    logic [DATA_LENGTH-1:0] data_mem[SETS][WAY_NUMBER];

    logic                   ack_r;
    logic [DATA_LENGTH-1:0] dat_r;
    logic                   hit_r;
    logic                   free_r;
    logic                   evict_r;
    logic [ADR_LENGTH-1:0]  evict_adr_r;
    logic [DATA_LENGTH-1:0] evict_dat_r;

    logic [INDEX_LENGTH-1:0] idx;
    logic [TAG_LENGTH-1:0]   tag;
    assign idx = key_q[KL-1 -: INDEX_LENGTH];
    assign tag = key_q[TAG_LENGTH-1:0];

    logic                   lk_hit;
    logic                   lk_free;
    age_t                   hit_way;
    age_t                   free_way;
    age_t                   lru_way;
    age_t                   way_sel;
    logic                   evict_now;
    logic [ADR_LENGTH-1:0]  ev_adr;

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        lk_hit   = 1'b0;
        lk_free  = 1'b0;
        hit_way  = '0;
        free_way = '0;
        lru_way  = '0;
        for (int w = WAY_NUMBER - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                lk_hit  = 1'b1;
                hit_way = age_t'(w);
            end
            if (!valid_q[idx][w]) begin
                lk_free  = 1'b1;
                free_way = age_t'(w);
            end
            if (age_q[idx][w] == age_t'(WAY_NUMBER - 1))
                lru_way = age_t'(w);
        end
    end

    assign way_sel   = lk_hit ? hit_way : (lk_free ? free_way : lru_way);
    assign evict_now = we_q && !deload_q && !lk_hit && !lk_free;

    // Victim address is rebuilt as {index, tag, zeros}.
    always_comb begin
        ev_adr = '0;
        ev_adr[ADR_LENGTH-1 -: KL] = {idx, tag_mem[idx][lru_way]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            deload_q    <= 1'b0;
            key_q       <= '0;
            dat_q       <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            ack_r       <= 1'b0;
            dat_r       <= '0;
            hit_r       <= 1'b0;
            free_r      <= 1'b0;
            evict_r     <= 1'b0;
            evict_adr_r <= '0;
            evict_dat_r <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAY_NUMBER; w++)
                    age_q[s][w] <= age_t'(w);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cc_req_i) begin
                        we_q     <= bus.cc_we_i;
                        deload_q <= bus.cc_deload_i;
                        key_q    <= bus.cc_adr_i[ADR_LENGTH-1 -: KL];
                        dat_q    <= bus.cc_dat_i;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    ack_r   <= 1'b1;
                    hit_r   <= lk_hit;
                    free_r  <= lk_free;
                    dat_r   <= (lk_hit && (!we_q || deload_q)) ?
                               data_mem[idx][hit_way] : '0;
                    evict_r <= evict_now;
                    evict_adr_r <= evict_now ? ev_adr : '0;
                    evict_dat_r <= evict_now ? data_mem[idx][lru_way] : '0;
                    hit_q   <= lk_hit;
                    way_q   <= way_sel;
                    state   <= RESP;
                end
                RESP: begin
                    ack_r   <= 1'b0;
                    hit_r   <= 1'b0;
                    evict_r <= 1'b0;
                    state   <= IDLE;
                    if (deload_q) begin
                        // Invalidated way becomes oldest; ages above it
                        // shift down so the set stays a permutation.
                        if (hit_q) begin
                            valid_q[idx][way_q] <= 1'b0;
                            for (int w = 0; w < WAY_NUMBER; w++) begin
                                if (age_t'(w) == way_q)
                                    age_q[idx][w] <= age_t'(WAY_NUMBER - 1);
                                else if (age_q[idx][w] > age_q[idx][way_q])
                                    age_q[idx][w] <= age_q[idx][w] - 1'b1;
                            end
                        end
                    end else if (we_q || hit_q) begin
                        if (we_q)
                            valid_q[idx][way_q] <= 1'b1;
                        for (int w = 0; w < WAY_NUMBER; w++) begin
                            if (age_t'(w) == way_q)
                                age_q[idx][w] <= '0;
                            else if (age_q[idx][w] < age_q[idx][way_q])
                                age_q[idx][w] <= age_q[idx][w] + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; a stale entry is masked by valid.
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && !deload_q) begin
            tag_mem[idx][way_q]  <= tag;
            data_mem[idx][way_q] <= dat_q;
        end
    end

    assign bus.cache_ack_o       = ack_r;
    assign bus.cache_dat_o       = dat_r;
    assign bus.cache_hit_o       = hit_r;
    assign bus.cache_free_o      = free_r;
    assign bus.cache_evict_o     = evict_r;
    assign bus.cache_evict_adr_o = evict_adr_r;
    assign bus.cache_evict_dat_o = evict_dat_r;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (ack_r) begin
            if (hit_r) begin
                if (hit_cnt_q != 16'hFFFF)
                    hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF)
                    miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign bus.cache_hit_cnt_o  = hit_cnt_q;
    assign bus.cache_miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_nway.sv
// Directed testbench for dcache_nway (2-way, 32 sets, 22-bit tag).
// Build with DCACHE_STATS_EN to also exercise the hit/miss counters.
module tb_dcache_nway;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_nway_if #(.ADR_LENGTH(32), .DATA_LENGTH(32)) bus ();

    dcache_nway #(
        .WAY_NUMBER(2), .ADR_LENGTH(32), .INDEX_LENGTH(5),
        .TAG_LENGTH(22), .DATA_LENGTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        a1, a2, h2, f2, e2, a3, h3;
    logic [31:0] d2, ea2, ed2, d3;

    task automatic do_req(input logic we, input logic dl,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cc_req_i    = 1'b1;
        bus.cc_we_i     = we;
        bus.cc_deload_i = dl;
        bus.cc_adr_i    = a;
        bus.cc_dat_i    = d;
        @(negedge clk);
        bus.cc_req_i = 1'b0;
        a1 = bus.cache_ack_o;
        @(negedge clk);
        a2  = bus.cache_ack_o;
        h2  = bus.cache_hit_o;
        f2  = bus.cache_free_o;
        e2  = bus.cache_evict_o;
        d2  = bus.cache_dat_o;
        ea2 = bus.cache_evict_adr_o;
        ed2 = bus.cache_evict_dat_o;
        @(negedge clk);
        a3 = bus.cache_ack_o;
        h3 = bus.cache_hit_o;
        d3 = bus.cache_dat_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cache_ack_o !== 1'b0 || bus.cache_hit_o !== 1'b0 ||
            bus.cache_evict_o !== 1'b0 || bus.cache_free_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ack=%b hit=%b ev=%b free=%b expected 0",
                     bus.cache_ack_o, bus.cache_hit_o,
                     bus.cache_evict_o, bus.cache_free_o);
        end
        checks++;
        if (bus.cache_dat_o !== 32'h0 || bus.cache_evict_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got dat=%h eadr=%h expected 0",
                     bus.cache_dat_o, bus.cache_evict_adr_o);
        end
    endtask

    task automatic test_read_miss();
        do_req(1'b0, 1'b0, 32'h0800_0010, 32'h0);
        checks++;
        if (a1 !== 1'b0 || a2 !== 1'b1 || a3 !== 1'b0) begin
            errors++;
            $display("FAIL miss_latency: got ack %b%b%b expected 010", a1, a2, a3);
        end
        checks++;
        if (h2 !== 1'b0 || f2 !== 1'b1 || d2 !== 32'h0) begin
            errors++;
            $display("FAIL miss_result: got hit=%b free=%b dat=%h expected 0 1 0",
                     h2, f2, d2);
        end
    endtask

    task automatic test_write_read();
        do_req(1'b1, 1'b0, 32'h0800_0010, 32'hDEAD_BEEF);
        checks++;
        if (h2 !== 1'b0 || e2 !== 1'b0 || f2 !== 1'b1) begin
            errors++;
            $display("FAIL wr_alloc: got hit=%b ev=%b free=%b expected 0 0 1",
                     h2, e2, f2);
        end
        do_req(1'b0, 1'b0, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'hDEAD_BEEF || e2 !== 1'b0) begin
            errors++;
            $display("FAIL rd_hit: got hit=%b dat=%h ev=%b expected 1 deadbeef 0",
                     h2, d2, e2);
        end
        checks++;
        if (h3 !== 1'b0 || d3 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_hold: got hit=%b dat=%h expected 0 deadbeef", h3, d3);
        end
        do_req(1'b1, 1'b0, 32'h0800_0010, 32'h1234_5678);
        checks++;
        if (h2 !== 1'b1 || e2 !== 1'b0) begin
            errors++;
            $display("FAIL wr_hit: got hit=%b ev=%b expected 1 0", h2, e2);
        end
        do_req(1'b0, 1'b0, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_after_wr_hit: got hit=%b dat=%h expected 1 12345678",
                     h2, d2);
        end
    endtask

    task automatic test_evict();
        do_req(1'b1, 1'b0, 32'h1800_0020, 32'hAAAA_0001);
        do_req(1'b1, 1'b0, 32'h1800_0040, 32'hBBBB_0002);
        checks++;
        if (f2 !== 1'b1 || e2 !== 1'b0) begin
            errors++;
            $display("FAIL ev_fill_b: got free=%b ev=%b expected 1 0", f2, e2);
        end
        do_req(1'b0, 1'b0, 32'h1800_0020, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL ev_read_a: got hit=%b dat=%h expected 1 aaaa0001", h2, d2);
        end
        do_req(1'b1, 1'b0, 32'h1800_0060, 32'hCCCC_0003);
        checks++;
        if (e2 !== 1'b1 || f2 !== 1'b0 || h2 !== 1'b0) begin
            errors++;
            $display("FAIL ev_flags: got ev=%b free=%b hit=%b expected 1 0 0",
                     e2, f2, h2);
        end
        checks++;
        if (ea2 !== 32'h1800_0040 || ed2 !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL ev_victim: got adr=%h dat=%h expected 18000040 bbbb0002",
                     ea2, ed2);
        end
        do_req(1'b0, 1'b0, 32'h1800_0020, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL ev_keep_a: got hit=%b dat=%h expected 1 aaaa0001", h2, d2);
        end
        do_req(1'b0, 1'b0, 32'h1800_0040, 32'h0);
        checks++;
        if (h2 !== 1'b0) begin
            errors++;
            $display("FAIL ev_gone_b: got hit=%b expected 0", h2);
        end
        do_req(1'b0, 1'b0, 32'h1800_0060, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL ev_new_c: got hit=%b dat=%h expected 1 cccc0003", h2, d2);
        end
    endtask

    task automatic test_deload();
        do_req(1'b0, 1'b1, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL deload_hit: got hit=%b dat=%h expected 1 12345678", h2, d2);
        end
        do_req(1'b0, 1'b0, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b0 || f2 !== 1'b1 || d2 !== 32'h0) begin
            errors++;
            $display("FAIL deload_after: got hit=%b free=%b dat=%h expected 0 1 0",
                     h2, f2, d2);
        end
        do_req(1'b0, 1'b1, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b0 || a2 !== 1'b1) begin
            errors++;
            $display("FAIL deload_miss: got hit=%b ack=%b expected 0 1", h2, a2);
        end
        do_req(1'b1, 1'b0, 32'h0800_0010, 32'h0000_0055);
        do_req(1'b1, 1'b1, 32'h0800_0010, 32'h0000_0099);
        checks++;
        if (h2 !== 1'b1 || d2 !== 32'h0000_0055) begin
            errors++;
            $display("FAIL deload_we: got hit=%b dat=%h expected 1 00000055", h2, d2);
        end
        do_req(1'b0, 1'b0, 32'h0800_0010, 32'h0);
        checks++;
        if (h2 !== 1'b0) begin
            errors++;
            $display("FAIL deload_we_after: got hit=%b expected 0", h2);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic hit_seen;
        n = 0;
        hit_seen = 1'b0;
        @(negedge clk);
        bus.cc_req_i    = 1'b1;
        bus.cc_we_i     = 1'b0;
        bus.cc_deload_i = 1'b0;
        bus.cc_adr_i    = 32'h1800_0020;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.cache_ack_o === 1'b1) begin
                n++;
                hit_seen = bus.cache_hit_o;
            end
            if (k == 1) bus.cc_req_i = 1'b0;
        end
        checks++;
        if (n != 1 || hit_seen !== 1'b1) begin
            errors++;
            $display("FAIL req_ignored: got acks=%0d hit=%b expected 1 1", n, hit_seen);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        @(negedge clk);
        bus.cc_req_i    = 1'b1;
        bus.cc_we_i     = 1'b1;
        bus.cc_deload_i = 1'b0;
        bus.cc_adr_i    = 32'h2000_0000;
        bus.cc_dat_i    = 32'h0000_0077;
        @(negedge clk);
        bus.cc_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.cache_ack_o === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rst_mid_ack: got acks=%0d expected 0", n);
        end
        do_req(1'b0, 1'b0, 32'h2000_0000, 32'h0);
        checks++;
        if (h2 !== 1'b0 || a2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_read: got hit=%b ack=%b expected 0 1", h2, a2);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b1, 1'b0, 32'h3000_0000, 32'h0000_0011);
        repeat (3) do_req(1'b0, 1'b0, 32'h3000_0000, 32'h0);
        do_req(1'b0, 1'b0, 32'h3800_0000, 32'h0);
        checks++;
        if (bus.cache_hit_cnt_o !== 16'd3 || bus.cache_miss_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL stats_count: got hit=%0d miss=%0d expected 3 2",
                     bus.cache_hit_cnt_o, bus.cache_miss_cnt_o);
        end
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        do_req(1'b0, 1'b0, 32'h3000_0000, 32'h0);
        checks++;
        if (bus.cache_hit_cnt_o !== 16'hFFFF || bus.cache_miss_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL stats_sat: got hit=%h miss=%0d expected ffff 2",
                     bus.cache_hit_cnt_o, bus.cache_miss_cnt_o);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cc_req_i    = 1'b0;
        bus.cc_we_i     = 1'b0;
        bus.cc_deload_i = 1'b0;
        bus.cc_adr_i    = '0;
        bus.cc_dat_i    = '0;
        test_reset();
        test_read_miss();
        test_write_read();
        test_evict();
        test_deload();
        test_back_to_back();
        test_reset_mid();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
